// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns (active-high, bit6=a .. bit0=g), hex decode and scan divider helper
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  function automatic int scan_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-high a..g pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex2seg(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit hex 7-segment driver with
// leading-zero blanking, per-digit dp and frame-boundary value updates
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  localparam int DIV = scan_div(CLK_HZ, SCAN_HZ);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  if (DIV < 2) begin : g_div_check
    $error("seg7_scan_driver: CLK_HZ/SCAN_HZ must be >= 2");
  end

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_d, disp_d;
  logic [NUM_DIGITS-1:0]   pend_p, disp_p;
  logic                    tick, wrap, blank;
  logic [3:0]              nib;
  logic [6:0]              seg;

  assign tick       = en && cnt == CW'(DIV - 1);
  assign wrap       = tick && idx == IW'(NUM_DIGITS - 1);
  assign frame_done = wrap;
  assign nib        = disp_d[{idx, 2'b00} +: 4];

  // a digit is blanked only when it and every more-significant digit are zero
  always_comb begin
    blank = blank_lz && idx != '0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx) && disp_d[4*j +: 4] != 4'h0) blank = 1'b0;
  end

  seg7_hex_decode u_dec (.nibble(nib), .seg(seg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      pend_d  <= '0;
      pend_p  <= '0;
      disp_d  <= '0;
      disp_p  <= '0;
      seg_out <= SEG_OFF;
      dp_out  <= SEG_ACT_LOW;
      an_out  <= AN_OFF;
    end else begin
      if (load) {pend_d, pend_p} <= {digits_in, dp_in};
      // a load on the wrapping tick bypasses pending so it is not lost a frame
      if (wrap) {disp_d, disp_p} <= load ? {digits_in, dp_in} : {pend_d, pend_p};
      cnt     <= (tick || !en) ? '0 : cnt + 1'b1;
      idx     <= (wrap || !en) ? '0 : idx + IW'(tick);
      seg_out <= (!en || blank) ? SEG_OFF : seg ^ SEG_OFF;
      dp_out  <= (en && disp_p[idx]) ^ SEG_ACT_LOW;
      an_out  <= en ? ((NUM_DIGITS'(1) << idx) ^ AN_OFF) : AN_OFF;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; a frame-position model predicts each cycle's outputs
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int DIV = 4;
  localparam int LAST = N * DIV - 1;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 0, rst = 1, en = 0, load = 0, blank_lz = 0;
  logic [15:0] digits_in = 0;
  logic [3:0]  dp_in = 0;
  logic [6:0]  seg_out;
  logic        dp_out, frame_done;
  logic [3:0]  an_out;

  seg7_scan_driver #(.NUM_DIGITS(N), .CLK_HZ(8), .SCAN_HZ(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_p = 0;
  logic [15:0] m_disp = 0, m_pend = 0;
  logic [3:0]  m_dpd = 0, m_dpp = 0;
  logic [6:0]  hex_hi [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  exp_t q[$];
  exp_t e, got;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // reference model: one position counter over the whole frame
  always @(posedge rst) begin
    m_p = 0; m_disp = 0; m_pend = 0; m_dpd = 0; m_dpp = 0;
  end

  initial forever begin
    int k;
    logic wrap, bl;
    @(posedge clk);
    e = '{7'h7F, 4'hF, 1'b1, 1'b0};
    if (!rst) begin
      k = m_p / DIV;
      if (en) begin
        bl = blank_lz && k > 0 && (m_disp >> (4 * k)) == 16'h0;
        e.seg = bl ? 7'h7F : ~hex_hi[m_disp[4*k +: 4]];
        e.an = ~(4'b0001 << k);
        e.dp = ~m_dpd[k];
      end
      wrap = en && m_p == LAST;
      if (load) begin m_pend = digits_in; m_dpp = dp_in; end
      if (wrap) begin m_disp = m_pend; m_dpd = m_dpp; end
      m_p = (en && !wrap) ? m_p + 1 : 0;
    end
    #2;
    e.fd = !rst && en && m_p == LAST;
    q.push_back(e);
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      got = q.pop_front();
      check("seg_out", {25'h0, seg_out}, {25'h0, got.seg});
      check("an_out", {28'h0, an_out}, {28'h0, got.an});
      check("dp_out", {31'h0, dp_out}, {31'h0, got.dp});
      check("frame_done", {31'h0, frame_done}, {31'h0, got.fd});
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    @(posedge clk); #1;
    load = 1; digits_in = d; dp_in = dp;
    @(posedge clk); #1;
    load = 0;
  endtask

  task automatic wait_p(input int target);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (m_p != target && n < 100);
    check("wait_p", m_p, target);
  endtask

  initial begin
    cycles(3);
    rst = 0; en = 1;
    cycles(6);
    do_load(16'h12AF, 4'b0000);
    cycles(40);
    blank_lz = 1;
    do_load(16'h0005, 4'b0000);
    cycles(36);
    blank_lz = 0;
    cycles(20);
    wait_p(5);
    load = 1; digits_in = 16'h1111; dp_in = 4'b0000;
    @(posedge clk); #1; load = 0;
    wait_p(LAST);
    load = 1; digits_in = 16'h2222;
    @(posedge clk); #1; load = 0;
    cycles(20);
    do_load(16'h3456, 4'b0100);
    cycles(36);
    wait_p(6);
    en = 0;
    cycles(5);
    en = 1;
    cycles(24);
    repeat (300) begin
      @(posedge clk); #1;
      en = $urandom_range(0, 15) != 0;
      load = $urandom_range(0, 5) == 0;
      digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
    end
    load = 0; en = 1;
    wait_p(9);
    @(negedge clk); #1;
    rst = 1;
    #1;
    check("async_seg", {25'h0, seg_out}, 32'h7F);
    check("async_an", {28'h0, an_out}, 32'hF);
    check("async_dp", {31'h0, dp_out}, 32'h1);
    #1 rst = 0;
    cycles(40);
    en = 0;
    cycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
